uart_tx_serializer: RTL and testbench
=====================================

// Module: uart_tx_serializer
// PURPOSE
//   Transmit engine of the 16550 UART. Pops bytes from the TX FIFO and serialises each byte onto tx_o
//   as start, data (LSB first), optional parity, then stop bits. Frame format is taken from the LCR fields
//   of csr_o; bit timing comes from the 16x baud_out pulse of the register block.
//   Drives the THRE/TEMT status sources back to the LSR.
// PARAMETERS
//   OVERSAMPLE   16   baud ticks per bit; must be even and >= 4
// PORTS
//   clk              in   1  system clock
//   rst              in   1  asynchronous, active-low reset (0 = reset)
//   baud_pulse_i     in   1  one-clk tick, OVERSAMPLE ticks per bit
//   tx_fifo_empty_i  in   1  TX FIFO empty
//   tx_fifo_dout_i   in   8  TX FIFO head word, first-word-fall-through
//   tx_pop_o         out  1  one-clk pop strobe to TX FIFO
//   wls_i            in   2  word length select: 00=5, 01=6, 10=7, 11=8 data bits
//   stb_i            in   1  0 = 1 stop bit; 1 = 2 stop bits (1.5 when wls=00)
//   pen_i            in   1  parity enable
//   eps_i            in   1  even parity select
//   stick_parity_i   in   1  stick parity
//   set_break_i      in   1  force line low
//   tx_o             out  1  serial output, idle high
//   busy_o           out  1  a frame is in progress
//   thre_o           out  1  = tx_fifo_empty_i (combinational)
//   temt_o           out  1  = tx_fifo_empty_i & ~busy_o (combinational)
// BEHAVIOUR
//   Reset: state=IDLE; tx_o=1, tx_pop_o=0, busy_o=0; all counters and shift register cleared.
//   FSM states: IDLE -> START -> DATA -> [PARITY if pen] -> STOP -> IDLE, or STOP -> START.
//   IDLE: on any clk with tx_fifo_empty_i=0, do the following in that cycle:
//     - assert tx_pop_o;
//     - capture tx_fifo_dout_i, wls, stb, pen, eps and stick into frame registers;
//     - go to START.
//     tx_o goes 0 on the next clk. LCR changes mid-frame affect the next frame only.
//   Bit timing: tick_cnt is cleared on entry to each bit and increments on every baud_pulse_i.
//     A bit ends on the clk where baud_pulse_i=1 and tick_cnt=OVERSAMPLE-1; the state advances on that clk.
//     With no ticks (divisor 0) the FSM stalls and tx_o holds its value.
//   DATA: sends 5+wls bits from the shift register, LSB first; bit_cnt counts down to 0.
//   PARITY bit value:
//     - stick=1: parity bit = ~eps.
//     - stick=0, eps=1: parity bit = XOR of the sent data bits only.
//     - stick=0, eps=0: parity bit = ~XOR of the sent data bits.
//     Unused upper data bits are excluded from the parity.
//   STOP: tx_o=1 for OVERSAMPLE ticks when stb=0. When stb=1: 1.5*OVERSAMPLE ticks if wls=00, else 2*OVERSAMPLE.
//   Back-to-back: at the end of STOP, if tx_fifo_empty_i=0, pop in that same clk and go straight to START (zero idle gap).
//     Otherwise go to IDLE.
//   busy_o is 1 from the clk after the pop through the last STOP clk. It is 0 in IDLE.
//   Break: while set_break_i=1, tx_o=0 (combinational override of the serialiser output).
//     The FSM keeps running and popping. Releasing the break restores the current bit.
//   tx_pop_o is never asserted while tx_fifo_empty_i=1. It is never asserted in two consecutive clks.
//   Reset mid-frame aborts immediately: tx_o=1, and the frame is lost.
//   FIFO flush (FCR tx_rst) is handled by the FIFO, not here; a frame in progress completes.
// TESTING
//   1) 8N1, byte 0x55, baud tick every 4 clk -> tx_o sees 0,1,0,1,0,1,0,1,0,1 with each level lasting 64 clk.
//      Exactly one tx_pop_o; busy_o then falls and temt_o=1.
//   2) 7E1 (wls=10, pen=1, eps=1), byte 0x41 -> data bits 1000001, then parity 0, then 1 stop.
//      Same byte with eps=0 gives parity 1.
//   3) 5-bit, stb=1, byte 0x1F -> stop high for 24 ticks. With wls=11, stb=1, the stop lasts 32 ticks.
//   4) Stick parity (pen=1, stick=1, eps=1), byte 0xFF -> parity bit 0. With eps=0 the parity bit is 1.
//   5) FIFO holds 0xA5 then 0x3C -> second start bit begins the clk after the last stop tick (no gap).
//      Two pops total; busy_o stays high throughout.
//   6) set_break_i=1 mid-DATA -> tx_o=0 immediately. Release -> tx_o resumes the correct bit.
//      Assert rst mid-frame -> tx_o=1, busy_o=0 asynchronously.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// UART transmit serialiser: pops bytes from a first-word-fall-through TX FIFO and shifts out start/data/parity/stop.
// Latency: line goes low the clk after the pop; each bit lasts OVERSAMPLE baud ticks; back-to-back frames have no gap.
module uart_tx_serializer #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_pulse_i,
    input  logic       tx_fifo_empty_i,
    input  logic [7:0] tx_fifo_dout_i,
    output logic       tx_pop_o,
    input  logic [1:0] wls_i,
    input  logic       stb_i,
    input  logic       pen_i,
    input  logic       eps_i,
    input  logic       stick_parity_i,
    input  logic       set_break_i,
    output logic       tx_o,
    output logic       busy_o,
    output logic       thre_o,
    output logic       temt_o
);
    localparam int TW = $clog2(2 * OVERSAMPLE);
    localparam logic [TW-1:0] LAST_1X  = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] LAST_15X = TW'(OVERSAMPLE + OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] LAST_2X  = TW'(2 * OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [1:0]    wls_q, wls_d;
    logic          stb_q, stb_d;
    logic          pen_q, pen_d;
    logic          par_q, par_d;
    logic          tx_q, tx_d;

    logic [TW-1:0] last_tick;
    logic          bit_end;
    logic          load;
    logic [7:0]    data_masked;
    logic          par_new;

    always_comb begin
        last_tick = LAST_1X;
        if (state_q == S_STOP && stb_q) begin
            last_tick = (wls_q == 2'b00) ? LAST_15X : LAST_2X;
        end
        bit_end = baud_pulse_i && (state_q != S_IDLE) && (tick_q == last_tick);
        load    = !tx_fifo_empty_i && ((state_q == S_IDLE) || (state_q == S_STOP && bit_end));

        // Parity is fixed at capture time over only the bits that will actually be sent.
        data_masked = tx_fifo_dout_i & (8'hFF >> (2'd3 - wls_i));
        if (stick_parity_i) begin
            par_new = ~eps_i;
        end else if (eps_i) begin
            par_new = ^data_masked;
        end else begin
            par_new = ~(^data_masked);
        end

        state_d   = state_q;
        tick_d    = tick_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        wls_d     = wls_q;
        stb_d     = stb_q;
        pen_d     = pen_q;
        par_d     = par_q;
        tx_d      = tx_q;

        if (state_q != S_IDLE && baud_pulse_i) begin
            tick_d = bit_end ? '0 : tick_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                tick_d = '0;
            end
            S_START: begin
                if (bit_end) begin
                    state_d   = S_DATA;
                    tx_d      = shift_q[0];
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_cnt_d = 3'd4 + {1'b0, wls_q};
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_cnt_q == 3'd0) begin
                        state_d = pen_q ? S_PARITY : S_STOP;
                        tx_d    = pen_q ? par_q : 1'b1;
                    end else begin
                        tx_d      = shift_q[0];
                        shift_d   = {1'b0, shift_q[7:1]};
                        bit_cnt_d = bit_cnt_q - 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    state_d = S_IDLE;
                    tx_d    = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // A pop in IDLE or at the last stop tick starts the next frame immediately.
        if (load) begin
            state_d = S_START;
            tick_d  = '0;
            tx_d    = 1'b0;
            shift_d = tx_fifo_dout_i;
            wls_d   = wls_i;
            stb_d   = stb_i;
            pen_d   = pen_i;
            par_d   = par_new;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            tick_q    <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            wls_q     <= '0;
            stb_q     <= 1'b0;
            pen_q     <= 1'b0;
            par_q     <= 1'b0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            wls_q     <= wls_d;
            stb_q     <= stb_d;
            pen_q     <= pen_d;
            par_q     <= par_d;
            tx_q      <= tx_d;
        end
    end

    assign tx_pop_o = load & rst;
    assign tx_o     = set_break_i ? 1'b0 : tx_q;
    assign busy_o   = (state_q != S_IDLE);
    assign thre_o   = tx_fifo_empty_i;
    assign temt_o   = tx_fifo_empty_i & ~busy_o;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: FIFO model, baud tick every 4 clk, line compared as runs of (level, length).
module tb_uart_tx_serializer;
    localparam int OS  = 16;
    localparam int CPT = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       baud_pulse_i = 1'b0;
    logic       tx_fifo_empty_i = 1'b1;
    logic [7:0] tx_fifo_dout_i = 8'h00;
    logic       tx_pop_o;
    logic [1:0] wls_i = 2'b11;
    logic       stb_i = 1'b0;
    logic       pen_i = 1'b0;
    logic       eps_i = 1'b0;
    logic       stick_parity_i = 1'b0;
    logic       set_break_i = 1'b0;
    logic       tx_o;
    logic       busy_o;
    logic       thre_o;
    logic       temt_o;

    uart_tx_serializer #(.OVERSAMPLE(OS)) dut (
        .clk             (clk),
        .rst             (rst),
        .baud_pulse_i    (baud_pulse_i),
        .tx_fifo_empty_i (tx_fifo_empty_i),
        .tx_fifo_dout_i  (tx_fifo_dout_i),
        .tx_pop_o        (tx_pop_o),
        .wls_i           (wls_i),
        .stb_i           (stb_i),
        .pen_i           (pen_i),
        .eps_i           (eps_i),
        .stick_parity_i  (stick_parity_i),
        .set_break_i     (set_break_i),
        .tx_o            (tx_o),
        .busy_o          (busy_o),
        .thre_o          (thre_o),
        .temt_o          (temt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic [1:0] wls;
        logic       stb;
        logic       pen;
        logic       eps;
        logic       stick;
        logic       par;
        int         stop_ticks;
    } vec_t;

    vec_t vecs[10];

    int   n_cmp = 0;
    int   n_err = 0;
    int   bcnt = 0;
    int   pop_cnt = 0;
    int   viol = 0;
    logic pop_pend = 1'b0;
    logic [7:0] fifo_q[$];
    logic [7:0] inject[$];
    logic obs_s[$];
    logic exp_s[$];
    logic work[$];
    logic r_lv[$];
    int   r_ln[$];
    logic o_lv[$];
    int   o_ln[$];
    logic e_lv[$];
    int   e_ln[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // One clock: FIFO model and baud generator update on the falling edge, outputs sampled 1 time unit later.
    task automatic step();
        @(negedge clk);
        if (pop_pend && fifo_q.size() > 0) void'(fifo_q.pop_front());
        bcnt = (bcnt + 1) % CPT;
        baud_pulse_i = (bcnt == 0);
        if (baud_pulse_i) while (inject.size() > 0) fifo_q.push_back(inject.pop_front());
        tx_fifo_empty_i = (fifo_q.size() == 0);
        tx_fifo_dout_i  = tx_fifo_empty_i ? 8'h00 : fifo_q[0];
        #1;
        if (tx_pop_o && tx_fifo_empty_i) viol++;
        if (tx_pop_o && pop_pend) viol++;
        pop_pend = tx_pop_o;
        if (tx_pop_o) pop_cnt++;
    endtask

    task automatic runs_of_work();
        r_lv.delete();
        r_ln.delete();
        foreach (work[i]) begin
            if (r_lv.size() > 0 && r_lv[r_lv.size()-1] == work[i]) begin
                r_ln[r_ln.size()-1] = r_ln[r_ln.size()-1] + 1;
            end else begin
                r_lv.push_back(work[i]);
                r_ln.push_back(1);
            end
        end
    endtask

    task automatic push_level(input logic lvl, input int ticks);
        for (int i = 0; i < ticks * CPT; i++) exp_s.push_back(lvl);
    endtask

    task automatic add_frame(input int idx);
        logic [7:0] d;
        d = vecs[idx].d;
        push_level(1'b0, OS);
        for (int i = 0; i < 5 + int'(vecs[idx].wls); i++) push_level(d[i], OS);
        if (vecs[idx].pen) push_level(vecs[idx].par, OS);
        push_level(1'b1, vecs[idx].stop_ticks);
    endtask

    task automatic run_frames(input int idx, input int n);
        bit started;
        bit done;
        int nr;
        wls_i = vecs[idx].wls;
        stb_i = vecs[idx].stb;
        pen_i = vecs[idx].pen;
        eps_i = vecs[idx].eps;
        stick_parity_i = vecs[idx].stick;
        obs_s.delete();
        exp_s.delete();
        pop_cnt = 0;
        for (int j = 0; j < n; j++) begin
            inject.push_back(vecs[idx + j].d);
            add_frame(idx + j);
        end
        started = 0;
        done = 0;
        for (int i = 0; i < 3000 && !done; i++) begin
            step();
            if (started) begin
                if (!busy_o) done = 1;
                else obs_s.push_back(tx_o);
            end else if (pop_pend) begin
                started = 1;
            end
        end
        chk($sformatf("v%0d frame_done", idx), done, 1);
        work = obs_s;
        runs_of_work();
        o_lv = r_lv;
        o_ln = r_ln;
        work = exp_s;
        runs_of_work();
        e_lv = r_lv;
        e_ln = r_ln;
        chk($sformatf("v%0d run_count", idx), o_lv.size(), e_lv.size());
        nr = (o_lv.size() < e_lv.size()) ? o_lv.size() : e_lv.size();
        for (int r = 0; r < nr; r++) begin
            chk($sformatf("v%0d run%0d_level", idx, r), o_lv[r], e_lv[r]);
            chk($sformatf("v%0d run%0d_len", idx, r), o_ln[r], e_ln[r]);
        end
        chk($sformatf("v%0d pops", idx), pop_cnt, n);
        chk($sformatf("v%0d busy_after", idx), busy_o, 0);
        chk($sformatf("v%0d temt_after", idx), temt_o, 1);
        chk($sformatf("v%0d tx_idle", idx), tx_o, 1);
    endtask

    initial begin
        //          d      wls    stb   pen   eps   stick par   stop
        vecs[0] = '{8'h55, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16};  // 8N1
        vecs[1] = '{8'h41, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16};  // 7E1
        vecs[2] = '{8'h41, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16};  // 7O1
        vecs[3] = '{8'h1F, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24};  // 5N1.5
        vecs[4] = '{8'hFF, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32};  // 8N2
        vecs[5] = '{8'hFF, 2'b11, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16};  // stick, eps=1
        vecs[6] = '{8'hFF, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16};  // stick, eps=0
        vecs[7] = '{8'hE0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16};  // upper bits excluded
        vecs[8] = '{8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16};  // back-to-back pair
        vecs[9] = '{8'h3C, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16};

        for (int i = 0; i < 3; i++) step();
        chk("rst tx", tx_o, 1);
        chk("rst busy", busy_o, 0);
        chk("rst pop", tx_pop_o, 0);
        chk("rst thre", thre_o, 1);
        chk("rst temt", temt_o, 1);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("idle tx", tx_o, 1);

        for (int v = 0; v < 8; v++) begin
            run_frames(v, 1);
            for (int i = 0; i < 7; i++) step();
        end
        run_frames(8, 2);
        for (int i = 0; i < 7; i++) step();

        // Break over a '1' data bit, then reset in the middle of a '0' data bit.
        wls_i = 2'b11; stb_i = 1'b0; pen_i = 1'b0; eps_i = 1'b0; stick_parity_i = 1'b0;
        inject.push_back(8'h55);
        pop_cnt = 0;
        for (int i = 0; i < 8 && pop_cnt == 0; i++) step();
        chk("brk popped", pop_cnt, 1);
        for (int i = 0; i < 100; i++) step();
        chk("brk pre bit0", tx_o, 1);
        set_break_i = 1'b1;
        #1;
        chk("brk immediate", tx_o, 0);
        for (int i = 0; i < 10; i++) step();
        chk("brk held", tx_o, 0);
        chk("brk busy", busy_o, 1);
        set_break_i = 1'b0;
        #1;
        chk("brk release bit0", tx_o, 1);
        for (int i = 0; i < 20; i++) step();
        chk("bit1 level", tx_o, 0);
        rst = 1'b0;
        #1;
        chk("arst tx", tx_o, 1);
        chk("arst busy", busy_o, 0);
        for (int i = 0; i < 3; i++) step();
        rst = 1'b1;
        for (int i = 0; i < 80; i++) step();
        chk("post rst tx", tx_o, 1);
        chk("post rst busy", busy_o, 0);
        chk("post rst temt", temt_o, 1);
        chk("pop rule violations", viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
